// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory responding to the core's
// request/response interface. Single-ported 32-bit word array with byte-lane
// writes, a configurable number of wait states between accept and response,
// and an error response for misaligned or out-of-range byte addresses.
// All response outputs and req_ready are registered, so there is no
// combinational path from req_* to rsp_*.

module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Word index width; a single-word array still needs one index bit.
    localparam int unsigned IDX_W = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;

    // First byte address past the end of the array (34 bits so the
    // comparison cannot overflow for any legal DEPTH_WORDS).
    localparam logic [33:0] BYTE_LIMIT = 34'(DEPTH_WORDS) << 2;

    // Wait counter reload value; the counter counts the remaining wait cycles
    // after the current one.
    localparam logic [3:0] LAT_M1 = (LATENCY > 32'd0) ? 4'(LATENCY - 32'd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         wait_cnt_r;

    // Request captured on the accept edge.
    logic               lat_we_r;
    logic [31:0]        lat_addr_r;
    logic [31:0]        lat_wdata_r;
    logic [3:0]         lat_be_r;

    // Fields of the access performed on the edge entering RESP.
    logic               acc_we_s;
    logic [31:0]        acc_addr_s;
    logic [31:0]        acc_wdata_s;
    logic [3:0]         acc_be_s;
    logic               acc_err_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic               enter_resp_s;

    logic [31:0]        mem_r [DEPTH_WORDS];

    // State register; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->)* RESP -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 32'd0) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && req_valid && (LATENCY != 32'd0)) begin
            wait_cnt_r <= LAT_M1;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Capture the request on the accept edge; later inputs are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
            lat_be_r    <= 4'd0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            lat_we_r    <= req_we;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            lat_be_r    <= req_be;
        end else begin
            lat_we_r    <= lat_we_r;
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
            lat_be_r    <= lat_be_r;
        end
    end

    // Select access fields: with zero wait states the access happens on the
    // accept edge itself, before the captured copy is available.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s    = req_we;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_we_s    = lat_we_r;
            acc_addr_s  = lat_addr_r;
            acc_wdata_s = lat_wdata_r;
            acc_be_s    = lat_be_r;
        end
    end

    // Access decode: misalignment and range check (all upper address bits
    // take part in the range check), word index and access strobe.
    always_comb begin
        acc_err_s = (acc_addr_s[1:0] != 2'b00) || ({2'b00, acc_addr_s} >= BYTE_LIMIT);
        acc_idx_s = acc_addr_s[IDX_W+1:2];
        if (!reset && (state_r != ST_RESP) && (state_next_s == ST_RESP)) begin
            enter_resp_s = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    // Array write: only enabled lanes of a good store, on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp_s && acc_we_s && !acc_err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be_s[i]) begin
                    mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Registered outputs: one-cycle response pulse, ready only in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp_s) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err_s;
            if (acc_we_s || acc_err_s) begin
                rsp_rdata <= 32'd0;
            end else begin
                rsp_rdata <= mem_r[acc_idx_s];
            end
        end else begin
            req_ready <= (state_next_s == ST_IDLE);
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances with LATENCY 1, 0 and 3.
// Table-driven request vectors plus hand-written sequences for back-to-back
// zero-latency requests and reset corner cases; expected responses go through
// a scoreboard queue.

module tb_mem_responder;

    localparam int NI = 3;

    logic        clk;
    logic        reset     [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    int lat_of [NI] = '{1, 0, 3};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q [$];
    vec_t vecs [15];

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .INIT_FILE("")) u0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .INIT_FILE("")) u1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(3), .INIT_FILE("")) u2 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full request/response transaction; called at a falling edge with the
    // instance idle, returns at the falling edge after the response.
    task automatic do_req(input int k, input vec_t v);
        exp_t e;
        int   n;
        e.k = k; e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb_q.push_back(e);
        check($sformatf("u%0d_ready_idle", k), {31'd0, req_ready[k]}, 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = v.we;
        req_addr[k]  = v.addr;
        req_wdata[k] = v.wdata;
        req_be[k]    = v.be;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        check($sformatf("u%0d_ready_busy", k), {31'd0, req_ready[k]}, 32'd0);
        n = 0;
        while (!rsp_valid[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_latency", k), n, lat_of[k]);
        e = sb_q.pop_front();
        check($sformatf("u%0d_rsp_valid", k), {31'd0, rsp_valid[k]}, 32'd1);
        check($sformatf("u%0d_rdata@%h", k, v.addr), rsp_rdata[k], e.rdata);
        check($sformatf("u%0d_err@%h", k, v.addr), {31'd0, rsp_err[k]}, {31'd0, e.err});
        check($sformatf("u%0d_ready_resp", k), {31'd0, req_ready[k]}, 32'd0);
        @(negedge clk);
        check($sformatf("u%0d_pulse_end", k), {31'd0, rsp_valid[k]}, 32'd0);
        check($sformatf("u%0d_rdata_clr", k), rsp_rdata[k], 32'd0);
        check($sformatf("u%0d_ready_back", k), {31'd0, req_ready[k]}, 32'd1);
    endtask

    // Watch for a spurious response over a number of cycles.
    task automatic expect_quiet(input int k, input int cycles, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) seen++;
        end
        check(name, seen, 32'd0);
    endtask

    initial begin
        vec_t v;
        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_be[k] = 4'd0;
        end

        // We, addr, wdata, be, expected rdata, expected err (LATENCY=1, 256 bytes)
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0050_0093, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0050_0093, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0050_0093, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[10] = '{1'b0, 32'h4000_0010, 32'h0,         4'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0011, 32'h5555_5555, 4'hF, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) reset[k] = 1'b0;

        // Reset values
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_rst_ready", k), {31'd0, req_ready[k]}, 32'd1);
            check($sformatf("u%0d_rst_valid", k), {31'd0, rsp_valid[k]}, 32'd0);
            check($sformatf("u%0d_rst_rdata", k), rsp_rdata[k], 32'd0);
            check($sformatf("u%0d_rst_err", k), {31'd0, rsp_err[k]}, 32'd0);
        end

        // Table-driven vectors on the LATENCY=1 instance
        for (int i = 0; i < 15; i++) do_req(0, vecs[i]);

        // LATENCY=0: preload, then hold req_valid high across three reads
        do_req(1, '{1'b1, 32'h0, 32'hA000_0000, 4'hF, 32'h0, 1'b0});
        do_req(1, '{1'b1, 32'h4, 32'hA000_0004, 4'hF, 32'h0, 1'b0});
        do_req(1, '{1'b1, 32'h8, 32'hA000_0008, 4'hF, 32'h0, 1'b0});
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_be[1] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.k = 1; e.rdata = 32'hA000_0000 + 32'(4 * i); e.err = 1'b0;
            sb_q.push_back(e);
            req_addr[1] = 32'(4 * i);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("b2b_valid%0d", i), {31'd0, rsp_valid[1]}, 32'd1);
            check($sformatf("b2b_rdata%0d", i), rsp_rdata[1], e.rdata);
            @(negedge clk);
            check($sformatf("b2b_gap%0d", i), {30'd0, rsp_valid[1], req_ready[1]}, 32'd1);
        end
        req_valid[1] = 1'b0;
        expect_quiet(1, 4, "b2b_tail");

        // LATENCY=3: reset during the second wait cycle aborts a write
        do_req(2, '{1'b1, 32'h20, 32'h0102_0304, 4'hF, 32'h0, 1'b0});
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
        req_wdata[2] = 32'hDEAD_BEEF; req_be[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        reset[2] = 1'b0;
        check("wait_rst_ready", {31'd0, req_ready[2]}, 32'd1);
        check("wait_rst_valid", {31'd0, rsp_valid[2]}, 32'd0);
        expect_quiet(2, 6, "wait_rst_quiet");
        v = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h0102_0304, 1'b0};
        do_req(2, v);

        // Reset and req_valid on the same edge: request dropped, then re-presented
        reset[2] = 1'b1; req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h20;
        @(negedge clk);
        reset[2] = 1'b0; req_valid[2] = 1'b0;
        check("rst_acc_ready", {31'd0, req_ready[2]}, 32'd1);
        expect_quiet(2, 6, "rst_acc_quiet");
        do_req(2, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
